insn_queue: RTL

INSN_QUEUE -- requirements
Module: insn_queue

---
 rtl/insn_queue.sv | 51 +++++
 1 files changed

// File: rtl/insn_queue.sv
// insn_queue: circular instruction buffer between the decoder and the dispatcher, with flush on mispredict
module insn_queue #(
    parameter int IQ_DEPTH = 8,
    parameter int PACK_W = 64,
    localparam int PW = $clog2(IQ_DEPTH),
    localparam int CW = $clog2(IQ_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              enq_valid,
    input  logic [PACK_W-1:0] enq_pack,
    input  logic              deq_stall,
    output logic              deq_valid,
    output logic [PACK_W-1:0] deq_pack,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count
);
    logic [PACK_W-1:0] mem [IQ_DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic              do_enq;
    logic              do_deq;

    assign full      = count == CW'(IQ_DEPTH);
    assign empty     = count == '0;
    assign deq_valid = !empty;
    assign do_enq    = enq_valid && !full && !flush;
    assign do_deq    = deq_valid && !deq_stall && !flush;
    assign deq_pack  = empty ? '0 : mem[head];

    // Pointers wrap naturally because IQ_DEPTH is a power of two; reset outranks flush.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(do_deq);
            tail  <= tail + PW'(do_enq);
            count <= count + CW'(do_enq) - CW'(do_deq);
        end
    end

    // Storage is never cleared; validity comes only from count and the pointers.
    always_ff @(posedge clk) begin
        if (do_enq && !reset)
            mem[tail] <= enq_pack;
    end
endmodule
